// File: rtl/sram_64x7_ctrl_if.sv
// sram_64x7_ctrl_if: request/response bus between a client and the SRAM controller
interface sram_64x7_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_addr;
  logic [6:0] req_wdata;
  logic [6:0] req_wmask;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [6:0] rsp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata);
  modport slave (input req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/sram_64x7_ctrl.sv
// sram_64x7_ctrl: 64x7 SRAM front end with zero-fill after reset and credit-limited in-order read responses
module sram_64x7_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_64x7_ctrl_if.slave  bus,
  output logic             busy,
  output logic             ce_in,
  output logic             we_in,
  output logic [5:0]       addr_in,
  output logic [6:0]       wd_in,
  output logic [6:0]       w_mask_in,
  input  logic [6:0]       rd_out
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int PW = RSP_DEPTH > 2 ? 2 : 1;
  state_t state;
  logic [5:0] cnt;
  logic inflight;
  logic [6:0] buf_q [RSP_DEPTH];
  logic [PW-1:0] rp, wp;
  logic [2:0] occ;
  logic clr, acc, pop;
  // Credits count the pop happening this cycle so a depth-2 buffer streams one read per cycle
  always_comb begin
    clr = !rst && state == CLEAR;
    bus.rsp_valid = !rst && occ != 3'd0;
    bus.rsp_rdata = bus.rsp_valid ? buf_q[rp] : 7'h00;
    pop = bus.rsp_valid && bus.rsp_ready;
    bus.req_ready = !rst && state == RUN && (3'(inflight) + occ - 3'(pop)) < 3'(RSP_DEPTH);
    acc = bus.req_valid && bus.req_ready;
    busy = clr;
    ce_in = clr || acc;
    we_in = clr || (acc && bus.req_we);
    addr_in = clr ? cnt : acc ? bus.req_addr : 6'd0;
    wd_in = acc ? bus.req_wdata : 7'h00;
    w_mask_in = clr ? 7'h7F : acc ? bus.req_wmask : 7'h00;
  end
  // Clear sequencing, in-flight read tracking and response FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt <= 6'd0;
      inflight <= 1'b0;
      rp <= '0;
      wp <= '0;
      occ <= 3'd0;
    end else begin
      if (state == CLEAR) begin
        cnt <= cnt + 6'd1;
        if (cnt == 6'd63) state <= RUN;
      end
      inflight <= acc && !bus.req_we;
      if (inflight) begin
        buf_q[wp] <= rd_out;
        wp <= wp == PW'(RSP_DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(RSP_DEPTH - 1) ? '0 : rp + 1'b1;
      occ <= occ + 3'(inflight) - 3'(pop);
    end
  end
endmodule
